// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg
//   Shared types and default constants for the PWM duty-cycle capture block.
//   pwm_state_e : capture FSM states (IDLE = unarmed, ACTIVE, INACTIVE)
//   *_DEF       : default parameter values used by pwm_duty_capture
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    INACTIVE
  } pwm_state_e;

  localparam int unsigned CNT_W_DEF    = 25;
  localparam int unsigned TIMEOUT_DEF  = 2 * 4800;
  localparam int unsigned FILT_LEN_DEF = 3;

endpackage

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync
//   Brings the asynchronous PWM line into the clk domain and produces
//   single-cycle strobes for the active and inactive edges.
//   Optional glitch filter enabled by defining PWM_GLITCH_FILTER_EN.
// Ports
//   clk        in  clock
//   rst        in  asynchronous active-low reset
//   pwm_in     in  raw PWM line (async)
//   level      out synchronized (and filtered) line level
//   act_edge   out 1-cycle strobe: level just entered the active value
//   inact_edge out 1-cycle strobe: level just left the active value
module pwm_edge_sync #(
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned FILT_LEN   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic level,
  output logic act_edge,
  output logic inact_edge
);

  // Level the line rests at when the LED is off.
  localparam logic INACT = ACTIVE_LOW;

  if (FILT_LEN == 0) begin : g_bad_filt_len
    $error("pwm_edge_sync: FILT_LEN must be at least 1");
  end

  logic sync1_q, sync2_q;
  logic s;
  logic s_d_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= INACT;
      sync2_q <= INACT;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM_GLITCH_FILTER_EN
  localparam int unsigned FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;

  // Counts consecutive samples that disagree with the filtered level; the
  // level follows only once FILT_LEN such samples have been seen in a row.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (sync2_q != filt_q) begin
      if (filt_cnt_q == FW'(FILT_LEN - 1)) begin
        filt_d = sync2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_q     <= INACT;
      filt_cnt_q <= '0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  assign s = filt_q;
`else
  assign s = sync2_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_d_q <= INACT;
    end else begin
      s_d_q <= s;
    end
  end

  assign level      = s;
  assign act_edge   = (s != s_d_q) && (s != INACT);
  assign inact_edge = (s != s_d_q) && (s == INACT);

endmodule

// File: rtl/pwm_duty_capture.sv
// pwm_duty_capture
//   Measures the period and active-phase width of an incoming PWM line and
//   flags a stalled (constant-level) line.
//   Optional glitch filter in pwm_edge_sync: define PWM_GLITCH_FILTER_EN.
// Ports
//   clk        in  clock
//   rst        in  asynchronous active-low reset
//   pwm_in     in  PWM line (async to clk)
//   clear      in  synchronous restart, drops any measurement in progress
//   period     out last full period in clk cycles (active edge to active edge)
//   width      out active-phase length of that period
//   meas_valid out 1-cycle pulse when period/width update
//   stalled    out no active edge within TIMEOUT cycles
//   level      out synchronized/filtered line level
module pwm_duty_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned FILT_LEN   = FILT_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  input  logic             clear,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] width,
  output logic             meas_valid,
  output logic             stalled,
  output logic             level
);

  if (TIMEOUT == 0 || 64'(TIMEOUT) >= (64'd1 << CNT_W)) begin : g_bad_timeout
    $error("pwm_duty_capture: TIMEOUT must be in 1..2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic act_edge, inact_edge;

  pwm_edge_sync #(
    .ACTIVE_LOW (ACTIVE_LOW),
    .FILT_LEN   (FILT_LEN)
  ) u_edge_sync (
    .clk        (clk),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .level      (level),
    .act_edge   (act_edge),
    .inact_edge (inact_edge)
  );

  pwm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] w_hold_q, w_hold_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic             mv_q, mv_d;
  logic             stalled_q, stalled_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             timeout;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout = (cnt_q == TIMEOUT_C);

  // State register plus datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      w_hold_q  <= '0;
      period_q  <= '0;
      width_q   <= '0;
      mv_q      <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      w_hold_q  <= w_hold_d;
      period_q  <= period_d;
      width_q   <= width_d;
      mv_q      <= mv_d;
      stalled_q <= stalled_d;
    end
  end

  // Next-state logic; clear overrides any edge seen in the same cycle.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (act_edge) state_d = ACTIVE;
        end
        ACTIVE: begin
          if (timeout)         state_d = IDLE;
          else if (inact_edge) state_d = INACTIVE;
        end
        INACTIVE: begin
          if (timeout)       state_d = IDLE;
          else if (act_edge) state_d = ACTIVE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath/output next values. The counter also runs while unarmed so a
  // line that never produces an active edge after reset/clear is still
  // reported as stalled once TIMEOUT cycles have elapsed.
  always_comb begin
    cnt_d     = cnt_inc;
    w_hold_d  = w_hold_q;
    period_d  = period_q;
    width_d   = width_q;
    mv_d      = 1'b0;
    stalled_d = stalled_q;
    if (clear) begin
      cnt_d     = '0;
      w_hold_d  = '0;
      period_d  = '0;
      width_d   = '0;
      stalled_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (act_edge) begin
            cnt_d     = CNT_W'(1);
            stalled_d = 1'b0;
          end else if (timeout) begin
            stalled_d = 1'b1;
          end
        end
        ACTIVE: begin
          if (timeout) begin
            cnt_d     = '0;
            stalled_d = 1'b1;
          end else if (inact_edge) begin
            w_hold_d = cnt_q;
          end
        end
        INACTIVE: begin
          if (timeout) begin
            cnt_d     = '0;
            stalled_d = 1'b1;
          end else if (act_edge) begin
            period_d = cnt_q;
            width_d  = w_hold_q;
            mv_d     = 1'b1;
            cnt_d    = CNT_W'(1);
          end
        end
        default: begin
          cnt_d = '0;
        end
      endcase
    end
  end

  assign period     = period_q;
  assign width      = width_q;
  assign meas_valid = mv_q;
  assign stalled    = stalled_q;

endmodule
